// File: rtl/countdown_timer.sv
// Programmable BCD countdown timer: synchronized tick_in rising edges decrement a DIGITS-wide BCD count
// under a load/run/pause/done FSM; commands act on the sampling edge, ticks land SYNC_STAGES edges after capture.
module countdown_timer #(
    parameter int DIGITS      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                stop,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                running,
    output logic                done,
    output logic                expired
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;
    logic                   tick_en;

    logic [1:0]   state_q;
    logic [1:0]   state_nxt;
    logic [W-1:0] count_q;
    logic [W-1:0] count_nxt;
    logic [W-1:0] load_clamped;
    logic [W-1:0] count_dec;
    logic         count_zero;
    logic         expired_q;
    logic         expired_nxt;

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Flops reset high so a tick_in already high at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign tick_en      = sync_out & ~prev_q;
    assign load_clamped = clamp_bcd(load_val);
    assign count_dec    = bcd_dec(count_q);
    assign count_zero   = (count_q == '0);

    always_comb begin
        state_nxt   = state_q;
        count_nxt   = count_q;
        expired_nxt = 1'b0;
        if (load) begin
            count_nxt = load_clamped;
            if (state_q == S_DONE) begin
                state_nxt = S_IDLE;
            end
        end else if (stop) begin
            if (state_q == S_RUN) begin
                state_nxt = S_PAUSE;
            end
        end else if (start) begin
            case (state_q)
                S_IDLE: begin
                    if (count_zero) begin
                        state_nxt   = S_DONE;
                        expired_nxt = 1'b1;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
                S_PAUSE: state_nxt = S_RUN;
                default: state_nxt = state_q;
            endcase
        end else if (tick_en && (state_q == S_RUN) && !count_zero) begin
            count_nxt = count_dec;
            if (count_dec == '0) begin
                state_nxt   = S_DONE;
                expired_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            count_q   <= count_nxt;
            expired_q <= expired_nxt;
        end
    end

    assign bcd_out = count_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: decimal-integer reference model checked every cycle, plus directed literal checks.
module tb_countdown_timer;

    localparam int DIGITS = 2;
    localparam int SS     = 2;
    localparam int W      = 4 * DIGITS;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick_in = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] bcd_out;
    logic         running;
    logic         done;
    logic         expired;

    int checks   = 0;
    int failures = 0;

    countdown_timer #(.DIGITS(DIGITS), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .bcd_out  (bcd_out),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (count kept as a plain decimal integer) ----------------
    int mcount;
    int mstate;
    bit mexp;
    bit hist [SS+1];   // hist[k] = tick_in sampled k+1 edges ago

    function automatic int bcd_to_int_clamped(input logic [W-1:0] v);
        int r, scale, d;
        r = 0;
        scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * scale;
            scale *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit tk;
        if (rst) begin
            mcount = 0;
            mstate = M_IDLE;
            mexp   = 1'b0;
            for (int k = 0; k <= SS; k++) hist[k] = 1'b1;
        end else begin
            tk = hist[SS-1] && !hist[SS];
            for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = tick_in;
            mexp = 1'b0;
            if (load) begin
                mcount = bcd_to_int_clamped(load_val);
                if (mstate == M_DONE) mstate = M_IDLE;
            end else if (stop) begin
                if (mstate == M_RUN) mstate = M_PAUSE;
            end else if (start) begin
                if (mstate == M_IDLE) begin
                    if (mcount == 0) begin
                        mstate = M_DONE;
                        mexp   = 1'b1;
                    end else begin
                        mstate = M_RUN;
                    end
                end else if (mstate == M_PAUSE) begin
                    mstate = M_RUN;
                end
            end else if (tk && mstate == M_RUN && mcount > 0) begin
                mcount = mcount - 1;
                if (mcount == 0) begin
                    mstate = M_DONE;
                    mexp   = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_bcd", 32'(bcd_out), 32'(int_to_bcd(mcount)));
        chk("model_running", 32'(running), 32'(mstate == M_RUN));
        chk("model_done", 32'(done), 32'(mstate == M_DONE));
        chk("model_expired", 32'(expired), 32'(mexp));
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_load(input logic [W-1:0] v);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Assumes tick_in has been low for at least SS+1 cycles; stop optionally lands on the tick edge.
    task automatic do_tick(input bit with_stop, output int exp_cnt);
        exp_cnt = 0;
        tick_in = 1'b1;
        @(negedge clk);
        exp_cnt += int'(expired);
        @(negedge clk);
        exp_cnt += int'(expired);
        stop = with_stop;
        @(negedge clk);
        exp_cnt += int'(expired);
        stop = 1'b0;
        @(negedge clk);
        exp_cnt += int'(expired);
        tick_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            exp_cnt += int'(expired);
        end
    endtask

    initial begin
        int ec;
        int cyc;

        // Reset with tick_in held high: no tick may appear.
        #1 rst = 1'b1;
        #13 rst = 1'b0;
        @(negedge clk);
        chk("reset_bcd", 32'(bcd_out), 32'h00);
        chk("reset_running", 32'(running), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_expired", 32'(expired), 32'h0);

        pulse_load(8'h05);
        pulse_start();
        repeat (4) @(negedge clk);
        chk("held_high_no_tick", 32'(bcd_out), 32'h05);

        // Tick latency: count changes on the third edge after tick_in is first sampled high.
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        chk("latency_e0", 32'(bcd_out), 32'h05);
        @(negedge clk);
        chk("latency_e1", 32'(bcd_out), 32'h05);
        @(negedge clk);
        chk("latency_e2", 32'(bcd_out), 32'h04);
        @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);

        // Borrow wrap.
        pulse_load(8'h10);
        chk("reload_in_run", 32'(running), 32'h1);
        do_tick(1'b0, ec);
        chk("borrow_wrap", 32'(bcd_out), 32'h09);
        do_tick(1'b0, ec);
        chk("after_wrap", 32'(bcd_out), 32'h08);
        chk("after_wrap_running", 32'(running), 32'h1);

        // Expiry.
        pulse_load(8'h02);
        do_tick(1'b0, ec);
        chk("expire_step1", 32'(bcd_out), 32'h01);
        do_tick(1'b0, ec);
        chk("expire_zero", 32'(bcd_out), 32'h00);
        chk("expire_pulse_count", 32'(ec), 32'd1);
        chk("expire_done", 32'(done), 32'h1);
        chk("expire_running", 32'(running), 32'h0);
        do_tick(1'b0, ec);
        chk("done_hold_zero", 32'(bcd_out), 32'h00);
        chk("done_no_pulse", 32'(ec), 32'd0);

        // Stop coincident with a tick, then pause/resume.
        pulse_load(8'h07);
        chk("load_from_done_idle", 32'(done), 32'h0);
        pulse_start();
        do_tick(1'b1, ec);
        chk("stop_wins_bcd", 32'(bcd_out), 32'h07);
        chk("stop_wins_paused", 32'(running), 32'h0);
        do_tick(1'b0, ec);
        chk("paused_hold", 32'(bcd_out), 32'h07);
        pulse_start();
        chk("resume_running", 32'(running), 32'h1);
        do_tick(1'b0, ec);
        chk("resume_tick", 32'(bcd_out), 32'h06);

        // Clamp, load from DONE, start at zero.
        pulse_load(8'hAF);
        chk("clamp", 32'(bcd_out), 32'h99);
        pulse_load(8'h01);
        do_tick(1'b0, ec);
        chk("reach_done", 32'(done), 32'h1);
        pulse_load(8'h03);
        chk("done_load_bcd", 32'(bcd_out), 32'h03);
        chk("done_load_idle", 32'(done | running), 32'h0);
        pulse_load(8'h00);
        pulse_start();
        chk("start_zero_done", 32'(done), 32'h1);
        chk("start_zero_expired", 32'(expired), 32'h1);
        @(negedge clk);
        chk("start_zero_expired_end", 32'(expired), 32'h0);

        // Asynchronous reset mid-run.
        pulse_load(8'h42);
        pulse_start();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bcd", 32'(bcd_out), 32'h00);
        chk("async_rst_running", 32'(running), 32'h0);
        chk("async_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        chk("post_rst_start_done", 32'(done), 32'h1);
        chk("post_rst_start_expired", 32'(expired), 32'h1);

        // Randomized phase, checked by the model.
        cyc = 0;
        fork
            begin
                while (cyc < 4000) begin
                    tick_in = ~tick_in;
                    repeat ($urandom_range(SS + 1, 10)) @(negedge clk);
                end
            end
            begin
                while (cyc < 4000) begin
                    load = ($urandom_range(0, 19) == 0);
                    if ($urandom_range(0, 1) == 0)
                        load_val = W'($urandom_range(0, 5));
                    else
                        load_val = W'($urandom);
                    start = ($urandom_range(0, 5) == 0);
                    stop  = ($urandom_range(0, 11) == 0);
                    if ($urandom_range(0, 599) == 0) begin
                        #2 rst = 1'b1;
                        #4 rst = 1'b0;
                    end
                    @(negedge clk);
                    cyc++;
                end
                load  = 1'b0;
                start = 1'b0;
                stop  = 1'b0;
            end
        join

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
